// File: rtl/trap_ctrl.sv
// Trap sequencer in front of the machine-mode CSR unit: prioritises exceptions, interrupts
// and mret at commit, then steps the CSR handshake and PC redirect through a short FSM.
module trap_ctrl #(
  parameter int unsigned MXLEN = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             instr_valid,
  input  logic [MXLEN-1:0] pc,
  input  logic             instr_misaligned,
  input  logic             instr_fault,
  input  logic             illegal_instr,
  input  logic             ecall,
  input  logic             ebreak,
  input  logic             load_misaligned,
  input  logic             load_fault,
  input  logic             store_misaligned,
  input  logic             store_fault,
  input  logic             mret_instr,
  input  logic             meip,
  input  logic             msip,
  input  logic             mtip,
  input  logic             mstatus_mie,
  input  logic             mie_meie,
  input  logic             mie_msie,
  input  logic             mie_mtie,
  output logic             kill,
  output logic             stall,
  output logic             flush,
  output logic             pc_load,
  output logic             exception,
  output logic             mret,
  output logic             csr_read,
  output logic [MXLEN-1:0] exception_num,
  output logic [MXLEN-1:0] pc_val
);

  typedef enum logic [1:0] {StIdle, StTrap, StRet, StRecover} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [MXLEN-1:0] r_exception_num;
  logic [MXLEN-1:0] r_pc_val;
  logic             w_irq;
  logic             w_sync;
  logic             w_trap;
  logic [MXLEN-1:0] w_cause;

  assign w_irq  = mstatus_mie & ((meip & mie_meie) | (msip & mie_msie) | (mtip & mie_mtie));
  assign w_sync = instr_misaligned | instr_fault | illegal_instr | ecall | ebreak |
                  load_misaligned | load_fault | store_misaligned | store_fault;
  assign w_trap = w_irq | w_sync;

  // Interrupts first, then synchronous exceptions in architectural priority order.
  always_comb begin
    w_cause = '0;
    if (w_irq) begin
      w_cause[MXLEN-1] = 1'b1;
      if (meip & mie_meie)      w_cause[3:0] = 4'd11;
      else if (msip & mie_msie) w_cause[3:0] = 4'd3;
      else                      w_cause[3:0] = 4'd7;
    end else if (instr_fault)      w_cause[3:0] = 4'd1;
    else if (illegal_instr)        w_cause[3:0] = 4'd2;
    else if (instr_misaligned)     w_cause[3:0] = 4'd0;
    else if (ecall)                w_cause[3:0] = 4'd11;
    else if (ebreak)               w_cause[3:0] = 4'd3;
    else if (store_misaligned)     w_cause[3:0] = 4'd6;
    else if (load_misaligned)      w_cause[3:0] = 4'd4;
    else if (store_fault)          w_cause[3:0] = 4'd7;
    else if (load_fault)           w_cause[3:0] = 4'd5;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (instr_valid && w_trap)          w_state_d = StTrap;
        else if (instr_valid && mret_instr) w_state_d = StRet;
      end
      StTrap:    w_state_d = StRecover;
      StRet:     w_state_d = StRecover;
      StRecover: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state         <= StIdle;
      r_exception_num <= '0;
      r_pc_val        <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && instr_valid) begin
        if (w_trap) begin
          r_exception_num <= w_cause;
          r_pc_val        <= pc;
        end else if (mret_instr) begin
          r_pc_val <= pc;
        end
      end
    end
  end

  // kill is gated by reset so a held-low RST never leaks a kill from live sources.
  always_comb begin
    kill      = RST && (r_state == StIdle) && instr_valid && w_trap;
    stall     = 1'b0;
    flush     = 1'b0;
    pc_load   = 1'b0;
    exception = 1'b0;
    mret      = 1'b0;
    csr_read  = 1'b0;
    unique case (r_state)
      StTrap: begin
        exception = 1'b1;
        csr_read  = 1'b1;
        pc_load   = 1'b1;
        stall     = 1'b1;
        flush     = 1'b1;
      end
      StRet: begin
        mret     = 1'b1;
        csr_read = 1'b1;
        pc_load  = 1'b1;
        stall    = 1'b1;
        flush    = 1'b1;
      end
      StRecover: flush = 1'b1;
      default: ;
    endcase
  end

  assign exception_num = r_exception_num;
  assign pc_val        = r_pc_val;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

  localparam int unsigned MXLEN = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             instr_valid;
  logic [MXLEN-1:0] pc;
  logic instr_misaligned, instr_fault, illegal_instr, ecall, ebreak;
  logic load_misaligned, load_fault, store_misaligned, store_fault;
  logic mret_instr, meip, msip, mtip, mstatus_mie, mie_meie, mie_msie, mie_mtie;
  logic kill, stall, flush, pc_load, exception, mret, csr_read;
  logic [MXLEN-1:0] exception_num;
  logic [MXLEN-1:0] pc_val;

  int n_checks = 0;
  int n_fail   = 0;

  // Output vector order: {kill, stall, flush, pc_load, exception, mret, csr_read}
  localparam logic [6:0] OutNone    = 7'b000_0000;
  localparam logic [6:0] OutKill    = 7'b100_0000;
  localparam logic [6:0] OutTrap    = 7'b011_1101;
  localparam logic [6:0] OutRet     = 7'b011_1011;
  localparam logic [6:0] OutRecover = 7'b001_0000;

  trap_ctrl #(.MXLEN(MXLEN)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .instr_valid      (instr_valid),
    .pc               (pc),
    .instr_misaligned (instr_misaligned),
    .instr_fault      (instr_fault),
    .illegal_instr    (illegal_instr),
    .ecall            (ecall),
    .ebreak           (ebreak),
    .load_misaligned  (load_misaligned),
    .load_fault       (load_fault),
    .store_misaligned (store_misaligned),
    .store_fault      (store_fault),
    .mret_instr       (mret_instr),
    .meip             (meip),
    .msip             (msip),
    .mtip             (mtip),
    .mstatus_mie      (mstatus_mie),
    .mie_meie         (mie_meie),
    .mie_msie         (mie_msie),
    .mie_mtie         (mie_mtie),
    .kill             (kill),
    .stall            (stall),
    .flush            (flush),
    .pc_load          (pc_load),
    .exception        (exception),
    .mret             (mret),
    .csr_read         (csr_read),
    .exception_num    (exception_num),
    .pc_val           (pc_val)
  );

  always #5 CLK = ~CLK;

  task automatic set_all(input logic v);
    instr_valid = v; instr_misaligned = v; instr_fault = v; illegal_instr = v;
    ecall = v; ebreak = v; load_misaligned = v; load_fault = v; store_misaligned = v;
    store_fault = v; mret_instr = v; meip = v; msip = v; mtip = v; mstatus_mie = v;
    mie_meie = v; mie_msie = v; mie_mtie = v;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {kill, stall, flush, pc_load, exception, mret, csr_read};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [MXLEN-1:0] obs,
                         input logic [MXLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs for a trapping instruction are already applied in IDLE.
  task automatic trap_seq(input string tag, input logic [MXLEN-1:0] cause,
                          input logic [MXLEN-1:0] tpc);
    @(negedge CLK);
    chk_out({tag, "_detect"}, OutKill);
    cyc();
    set_all(1'b0);
    @(negedge CLK);
    chk_out({tag, "_trap"}, OutTrap);
    chk_val({tag, "_cause"}, exception_num, cause);
    chk_val({tag, "_pc"}, pc_val, tpc);
    cyc();
    @(negedge CLK);
    chk_out({tag, "_recover"}, OutRecover);
    cyc();
    @(negedge CLK);
    chk_out({tag, "_idle"}, OutNone);
  endtask

  initial begin
    // Reset with every source asserted
    RST = 1'b0;
    set_all(1'b1);
    pc = 32'hFFFF_FFFC;
    cyc();
    cyc();
    @(negedge CLK);
    chk_out("reset_outs", OutNone);
    chk_val("reset_cause", exception_num, 32'h0);
    chk_val("reset_pc", pc_val, 32'h0);
    cyc();
    RST = 1'b1;
    set_all(1'b0);
    @(negedge CLK);
    chk_out("post_reset", OutNone);
    cyc();
    @(negedge CLK);
    chk_out("post_reset2", OutNone);

    // Sources without instr_valid are ignored
    cyc();
    illegal_instr = 1'b1; ecall = 1'b1; mret_instr = 1'b1;
    @(negedge CLK);
    chk_out("novalid_comb", OutNone);
    cyc();
    set_all(1'b0);
    @(negedge CLK);
    chk_out("novalid_next", OutNone);

    cyc();
    instr_valid = 1'b1; illegal_instr = 1'b1; pc = 32'h0000_0100;
    trap_seq("illegal", 32'd2, 32'h100);

    cyc();
    instr_valid = 1'b1; instr_fault = 1'b1; illegal_instr = 1'b1; load_fault = 1'b1;
    pc = 32'h0000_0104;
    trap_seq("prio_ifault", 32'd1, 32'h104);

    cyc();
    instr_valid = 1'b1; store_fault = 1'b1; load_fault = 1'b1; pc = 32'h0000_0108;
    trap_seq("prio_sfault", 32'd7, 32'h108);

    cyc();
    instr_valid = 1'b1; mstatus_mie = 1'b1; mie_mtie = 1'b1; mtip = 1'b1; ecall = 1'b1;
    pc = 32'h0000_010C;
    trap_seq("irq_mti", 32'h8000_0007, 32'h10C);

    cyc();
    instr_valid = 1'b1; mstatus_mie = 1'b0; mie_mtie = 1'b1; mtip = 1'b1; ecall = 1'b1;
    pc = 32'h0000_0110;
    trap_seq("irq_masked", 32'd11, 32'h110);

    cyc();
    instr_valid = 1'b1; mstatus_mie = 1'b1; ecall = 1'b1;
    meip = 1'b1; msip = 1'b1; mtip = 1'b1; mie_meie = 1'b1; mie_msie = 1'b1; mie_mtie = 1'b1;
    pc = 32'h0000_0114;
    trap_seq("irq_mei", 32'h8000_000B, 32'h114);

    cyc();
    instr_valid = 1'b1; mstatus_mie = 1'b1; msip = 1'b1; mtip = 1'b1;
    mie_msie = 1'b1; mie_mtie = 1'b1; pc = 32'h0000_0118;
    trap_seq("irq_msi", 32'h8000_0003, 32'h118);

    // MRET with no trap; cause register must hold
    cyc();
    instr_valid = 1'b1; mret_instr = 1'b1; pc = 32'h0000_0200;
    @(negedge CLK);
    chk_out("mret_detect", OutNone);
    cyc();
    set_all(1'b0);
    @(negedge CLK);
    chk_out("mret_ret", OutRet);
    chk_val("mret_pc", pc_val, 32'h200);
    chk_val("mret_cause_hold", exception_num, 32'h8000_0003);
    cyc();
    @(negedge CLK);
    chk_out("mret_recover", OutRecover);
    cyc();
    @(negedge CLK);
    chk_out("mret_idle", OutNone);

    cyc();
    instr_valid = 1'b1; mret_instr = 1'b1; ebreak = 1'b1; pc = 32'h0000_0204;
    trap_seq("mret_ebreak", 32'd3, 32'h204);

    // Reset during TRAP aborts the sequence
    cyc();
    instr_valid = 1'b1; illegal_instr = 1'b1; pc = 32'h0000_0300;
    cyc();
    set_all(1'b0);
    @(negedge CLK);
    chk_out("abort_trap", OutTrap);
    RST = 1'b0;
    cyc();
    @(negedge CLK);
    chk_out("abort_reset", OutNone);
    chk_val("abort_cause", exception_num, 32'h0);
    chk_val("abort_pc", pc_val, 32'h0);
    cyc();
    RST = 1'b1;
    @(negedge CLK);
    chk_out("abort_after1", OutNone);
    cyc();
    @(negedge CLK);
    chk_out("abort_after2", OutNone);

    // Sources during RECOVER are ignored
    cyc();
    instr_valid = 1'b1; illegal_instr = 1'b1; pc = 32'h0000_0400;
    cyc();
    set_all(1'b0);
    @(negedge CLK);
    chk_out("ign_trap", OutTrap);
    cyc();
    instr_valid = 1'b1; illegal_instr = 1'b1; pc = 32'h0000_0500;
    @(negedge CLK);
    chk_out("ign_recover", OutRecover);
    cyc();
    set_all(1'b0);
    @(negedge CLK);
    chk_out("ign_idle", OutNone);
    chk_val("ign_pc_hold", pc_val, 32'h400);
    cyc();
    @(negedge CLK);
    chk_out("ign_idle2", OutNone);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer directly upstream of the machine-mode CSR unit.
- Collects synchronous exception flags, interrupt pendings and mret from the execute stage at instruction boundaries, then prioritises them.
- Drives the CSR unit's exception, exception_num, mret, csr_read and pc_val inputs through a short FSM.
- Stalls and flushes the pipeline while the PC is redirected to the r_data returned by the CSR unit.

Parameters:
- MXLEN, 32, data/address width; must equal the codebase `MXLEN.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-low: state is cleared on the rising CLK edge while RST=0.
- instr_valid  in  1  execute-stage instruction is at its commit boundary this cycle.
- pc  in  MXLEN  PC of that instruction.
- instr_misaligned, instr_fault, illegal_instr, ecall, ebreak, load_misaligned, load_fault, store_misaligned, store_fault  in  1 each  synchronous exception flags.
- mret_instr  in  1  decoded MRET.
- meip, msip, mtip  in  1 each  external, software and timer interrupt pending.
- mstatus_mie  in  1  global interrupt enable.
- mie_meie, mie_msie, mie_mtie  in  1 each  per-source enables.
- kill  out  1  suppress commit/write-back of the current instruction (combinational).
- stall  out  1  freeze IF/ID/EX.
- flush  out  1  invalidate IF/ID contents.
- pc_load  out  1  load PC from CSR r_data this cycle.
- exception  out  1  to CSR unit.
- mret  out  1  to CSR unit.
- csr_read  out  1  to CSR unit (vector/mepc fetch).
- exception_num  out  MXLEN  mcause value to CSR unit.
- pc_val  out  MXLEN  latched trap PC to CSR unit.

Behaviour:
- FSM states: IDLE, TRAP, RET, RECOVER. Reset (RST=0) forces IDLE, clears all registered outputs, exception_num=0 and pc_val=0.
- Reset mid-sequence aborts the sequence; no exception/mret pulse is issued afterwards.
- In IDLE, sources are evaluated only when instr_valid=1; when instr_valid=0, all sources are ignored.
- Interrupt taken if mstatus_mie=1 and (meip&mie_meie | msip&mie_msie | mtip&mie_mtie).
  - Interrupts win over synchronous exceptions.
  - Interrupt priority: MEI (cause 0x8000000B) > MSI (0x80000003) > MTI (0x80000007).
- Synchronous exception priority, highest first, with cause codes:
  - instr_fault (1), illegal_instr (2), instr_misaligned (0), ecall (11), ebreak (3), store_misaligned (6), load_misaligned (4), store_fault (7), load_fault (5).
- Any trap or exception beats mret_instr.
- Detection cycle (IDLE, trap found):
  - kill=1 combinationally in the same cycle.
  - Next edge: exception_num <= cause, pc_val <= pc, state <= TRAP.
- TRAP (exactly 1 cycle): exception=1, csr_read=1, pc_load=1, stall=1, flush=1. Next state RECOVER.
- mret_instr with no trap (IDLE, instr_valid=1): kill=0; pc_val <= pc; state <= RET.
- RET (exactly 1 cycle): mret=1, csr_read=1, pc_load=1, stall=1, flush=1. Next state RECOVER.
- RECOVER (exactly 1 cycle): stall=0, flush=1, all others 0. Next state IDLE. Sources are ignored in RECOVER.
- In TRAP, RET and RECOVER, all source inputs are ignored; kill=0.
- Registered outputs (exception, mret, csr_read, pc_load, stall, flush) are decoded from the state register. They are never asserted in IDLE.
- exception_num and pc_val hold their last value outside detection edges.
- Latency: detection edge to exception/pc_load is 1 cycle; the next instruction can be accepted 3 cycles after the detection cycle.
- exception and mret are mutually exclusive and never asserted back-to-back without an intervening RECOVER.

Test Plan:
- Reset: hold RST=0 for 2 cycles with all sources=1 -> all outputs 0, exception_num=0; after RST=1 with instr_valid=0 -> outputs stay 0.
- Illegal instruction: instr_valid=1, illegal_instr=1, pc=0x00000100 -> kill=1 in the same cycle; next cycle exception=1, csr_read=1, pc_load=1, exception_num=2, pc_val=0x100; then RECOVER with flush=1; then IDLE.
- Priority: instr_fault=1, illegal_instr=1, load_fault=1 together -> exception_num=1. Separately, store_fault+load_fault -> exception_num=7.
- Interrupt vs exception: mstatus_mie=1, mie_mtie=1, mtip=1, ecall=1 -> exception_num=0x80000007. Repeat with mstatus_mie=0 -> exception_num=11. Repeat with meip+msip+mtip all enabled -> 0x8000000B.
- MRET: mret_instr=1, pc=0x200 -> kill=0; next cycle mret=1, csr_read=1, pc_load=1, exception=0; then RECOVER. mret_instr with ebreak=1 -> exception with cause 3, mret never asserted.
- Reset mid-sequence and ignore window: assert RST=0 during TRAP -> IDLE, no further pulses. Assert illegal_instr during RECOVER -> no trap is started.
